// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-LCD feed: receiver/output state encodings and timing constants.
// No logic; consumed at elaboration only.
// Not applicable (no datapath).
package uart_pkg;

   // Oversample ratio of the receiver relative to the bit rate
   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = $clog2(OVERSAMPLE);

   // Tick index of the mid-start-bit sample and of each full-bit sample
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);

   // Cycles after the strobe during which busy is not trusted (consumer registers busy late)
   localparam logic [1:0] HOLD_IGNORE = 2'd2;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      O_IDLE   = 2'd0,
      O_STROBE = 2'd1,
      O_HOLD   = 2'd2
   } out_state_t;

   // Clocks per oversample tick, never below one
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, power-of-two depth, first-word-fall-through head (dout = oldest byte).
// Push visible in count/empty one cycle later; dout is combinational from the read pointer.
// Push when full is refused unless a pop happens in the same cycle; pop when empty is ignored.
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot being written, so a full FIFO still accepts the push
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; count moves only on unbalanced push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_feed.sv
// 8N1 UART receiver feeding an LCD controller through a byte FIFO with a busy handshake.
// Byte strobed to the LCD ~2 clocks after the stop-bit sample when the FIFO was empty and busy is low.
// busy stalls the output side; a full FIFO drops the incoming byte and pulses overrun.
module uart_rx_feed
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           rx,
   input  logic                           busy,
   output logic [7:0]                     lcd_data,
   output logic                           lcd_we,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           overrun,
   output logic                           frame_err
);

   localparam int DIV   = calc_div(CLK_HZ, BAUD);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   logic              rx_meta, rx_sync, rx_prev;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic              start_edge;
   logic [TICK_W-1:0] tick_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   rx_state_t         rx_state, rx_next;
   out_state_t        out_state, out_next;
   logic [1:0]        hold_cnt;
   logic              push, pop, ferr_set;
   logic              full, empty;
   logic [7:0]        head;

   assign start_edge = (rx_state == R_IDLE) && rx_prev && !rx_sync;
   assign tick       = (div_cnt == DIV_LAST);
   assign lcd_we     = (out_state == O_STROBE);

   // Two-flop synchroniser plus previous-sample flop for falling-edge detection; idle high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Free-running oversample divider, realigned to the start edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 div_cnt <= '0;
      else if (start_edge || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DIV_W'(1);
   end

   // Receiver state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rx_state <= R_IDLE;
      else       rx_state <= rx_next;
   end

   // Receiver next state; push/frame error decided at the stop-bit sample
   always_comb begin
      rx_next  = rx_state;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (rx_state)
         R_IDLE:  if (start_edge) rx_next = R_START;
         R_START: if (tick && tick_cnt == HALF_LAST) rx_next = rx_sync ? R_IDLE : R_DATA;
         R_DATA:  if (tick && tick_cnt == BIT_LAST && bit_cnt == 3'd7) rx_next = R_STOP;
         R_STOP: begin
            if (tick && tick_cnt == BIT_LAST) begin
               rx_next  = R_IDLE;
               push     = rx_sync;
               ferr_set = !rx_sync;
            end
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // Tick/bit counters and LSB-first shift register; the start sample realigns ticks to bit centres
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else if (rx_state == R_IDLE) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else if (tick) begin
         tick_cnt <= (rx_state == R_START && tick_cnt == HALF_LAST) ? '0 : tick_cnt + TICK_W'(1);
         if (rx_state == R_DATA && tick_cnt == BIT_LAST) begin
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // Error pulses, one cycle after the event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= push && full && !pop;
         frame_err <= ferr_set;
      end
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (shift),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Output state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) out_state <= O_IDLE;
      else       out_state <= out_next;
   end

   // Output handshake: pop on leaving idle, strobe once, then hold until busy can be trusted and is low
   always_comb begin
      out_next = out_state;
      pop      = 1'b0;
      case (out_state)
         O_IDLE: begin
            if (!empty && !busy) begin
               out_next = O_STROBE;
               pop      = 1'b1;
            end
         end
         O_STROBE: out_next = O_HOLD;
         O_HOLD:   if (hold_cnt == HOLD_IGNORE && !busy) out_next = O_IDLE;
         default:  out_next = O_IDLE;
      endcase
   end

   // Hold counter and LCD data register; data changes only on a pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt <= '0;
         lcd_data <= '0;
      end else begin
         if (out_state != O_HOLD)        hold_cnt <= '0;
         else if (hold_cnt != HOLD_IGNORE) hold_cnt <= hold_cnt + 2'd1;
         if (pop) lcd_data <= head;
      end
   end

endmodule

// File: tb/tb_uart_rx_feed.sv
// Directed bench for uart_rx_feed at 32 clocks per bit.
// Frames driven on falling clock edges; outputs observed on falling edges.
// busy is driven directly to exercise stall, overrun and hold behaviour.
module tb_uart_rx_feed;
   import uart_pkg::*;

   localparam int BITCLK = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       busy;
   logic [7:0] lcd_data;
   logic       lcd_we;
   logic [3:0] fifo_count;
   logic       overrun;
   logic       frame_err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Cumulative monitor state; tests work on deltas
   int          we_cnt   = 0;
   int          ovr_cnt  = 0;
   int          ferr_cnt = 0;
   int          data_cyc = 0;
   logic [7:0]  we_dat [$];
   int          we_cyc [$];

   uart_rx_feed #(.CLK_HZ(3200000), .BAUD(100000), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .busy       (busy),
      .lcd_data   (lcd_data),
      .lcd_we     (lcd_we),
      .fifo_count (fifo_count),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lcd_we) begin
         we_cnt = we_cnt + 1;
         we_dat.push_back(lcd_data);
         we_cyc.push_back(cyc);
      end
      if (overrun)   ovr_cnt  = ovr_cnt + 1;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (dut.rx_state == R_DATA) data_cyc = data_cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive {stop, data, start} LSB first for nclk clocks, idle high afterwards
   task automatic drive_frame(input logic [7:0] b, input logic stop, input int nclk, output int t0);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      t0 = 0;
      for (int i = 0; i < nclk; i++) begin
         @(negedge clk);
         if (i == 0) t0 = cyc;
         rx = (i / BITCLK < 10) ? f[i / BITCLK] : 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      int t;
      drive_frame(b, stop, 11 * BITCLK, t);
   endtask

   initial begin
      int t0, base, obase, fbase, dbase, fall, n, ok;
      reset = 1'b1;
      rx    = 1'b1;
      busy  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data",  lcd_data,   8'h00);
      chk("rst_we",    lcd_we,     1'b0);
      chk("rst_count", fifo_count, 4'd0);
      chk("rst_ovr",   overrun,    1'b0);
      chk("rst_ferr",  frame_err,  1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte, consumer idle
      base = we_cnt;
      drive_frame(8'h41, 1'b1, 11 * BITCLK, t0);
      chk("a41_we",    we_cnt - base, 1);
      chk("a41_data",  we_dat[base], 8'h41);
      ok = (we_cyc[base] - t0 >= 306 && we_cyc[base] - t0 <= 310) ? 1 : 0;
      chk("a41_lat",   ok, 1);
      chk("a41_count", fifo_count, 4'd0);

      // Stop bit low
      base = we_cnt; fbase = ferr_cnt;
      send(8'h5A, 1'b0);
      chk("ferr_pulse", ferr_cnt - fbase, 1);
      chk("ferr_we",    we_cnt - base, 0);
      chk("ferr_count", fifo_count, 4'd0);

      // 10-clock glitch
      base = we_cnt; fbase = ferr_cnt; obase = ovr_cnt; dbase = data_cyc;
      @(negedge clk); rx = 1'b0;
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (400) @(negedge clk);
      chk("glitch_data",  data_cyc - dbase, 0);
      chk("glitch_count", fifo_count, 4'd0);
      chk("glitch_we",    we_cnt - base, 0);
      chk("glitch_flags", (ferr_cnt - fbase) + (ovr_cnt - obase), 0);

      // Fill under busy, overrun on the ninth byte, then drain in order
      busy = 1'b1;
      base = we_cnt; obase = ovr_cnt;
      for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b1);
      chk("fill_count8", fifo_count, 4'd8);
      chk("fill_novr",   ovr_cnt - obase, 0);
      send(8'h38, 1'b1);
      chk("ovr_pulse",   ovr_cnt - obase, 1);
      chk("ovr_count",   fifo_count, 4'd8);
      chk("ovr_no_we",   we_cnt - base, 0);
      @(negedge clk); busy = 1'b0;
      repeat (80) @(negedge clk);
      chk("drain_we",    we_cnt - base, 8);
      for (int i = 0; i < 8; i++) begin
         if (we_cnt - base > i) chk($sformatf("drain_dat%0d", i), we_dat[base + i], 8'h30 + 8'(i));
         else                   chk($sformatf("drain_dat%0d", i), 32'hDEAD, 8'h30 + 8'(i));
      end
      ok = 1;
      for (int i = 1; i < 8; i++) if (we_cnt - base > i && we_cyc[base + i] - we_cyc[base + i - 1] < 4) ok = 0;
      chk("drain_spacing", ok, 1);
      chk("drain_count",   fifo_count, 4'd0);

      // Reset in the middle of data bit 4 of 0x55
      base = we_cnt;
      drive_frame(8'h55, 1'b1, 5 * BITCLK + BITCLK / 2, t0);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_we",    lcd_we, 1'b0);
      chk("mid_rst_count", fifo_count, 4'd0);
      reset = 1'b0;
      repeat (400) @(negedge clk);
      chk("post_rst_we",   we_cnt - base, 0);
      send(8'h0D, 1'b1);
      chk("cr_we",   we_cnt - base, 1);
      chk("cr_data", (we_cnt > base) ? we_dat[base] : 8'h00, 8'h0D);

      // Two queued bytes, consumer busy for 100 cycles after the first strobe
      busy = 1'b1;
      base = we_cnt;
      send(8'h61, 1'b1);
      send(8'h62, 1'b1);
      chk("hs_count2", fifo_count, 4'd2);
      busy = 1'b0;
      n = 0;
      while (we_cnt == base && n < 50) begin @(negedge clk); n++; end
      chk("hs_first_seen", (we_cnt > base) ? 1 : 0, 1);
      @(posedge clk); #1 busy = 1'b1;
      repeat (100) @(posedge clk);
      #1 busy = 1'b0;
      fall = cyc;
      chk("hs_held", we_cnt - base, 1);
      n = 0;
      while (we_cnt < base + 2 && n < 50) begin @(negedge clk); n++; end
      chk("hs_second_seen", (we_cnt >= base + 2) ? 1 : 0, 1);
      if (we_cnt >= base + 2) begin
         chk("hs_gap",   (we_cyc[base + 1] >= fall + 1) ? 1 : 0, 1);
         chk("hs_dat0",  we_dat[base],     8'h61);
         chk("hs_dat1",  we_dat[base + 1], 8'h62);
      end
      repeat (10) @(negedge clk);
      chk("hs_count0", fifo_count, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
